// File: rtl/bf_uart_rx.sv
// 8N1 UART receiver feeding a small first-word-fall-through byte FIFO.
// All logic runs on clk; uart_rx_pin is synchronised before use.
`timescale 1ns/1ps
module bf_uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // state     | meaning
    // S_IDLE    | line idle, waiting for a falling edge on rxs
    // S_START   | timing to mid start bit, rejecting glitches
    // S_DATA    | sampling 8 data bits LSB first
    // S_STOP    | sampling stop bit; push byte or flag framing error
    // S_WAIT_HIGH | after a framing error, hold until the line is high again

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          rx_meta, rxs;
    logic          push_req, ferr_req;
    logic          tc;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_pin;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    assign tc = (cnt == '0);

    // Bit timer is a down-counter reloaded at each sample point.
    always_comb begin
        state_nx   = state;
        cnt_nx     = tc ? cnt : cnt - CW'(1);
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        push_req   = 1'b0;
        ferr_req   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_nx = S_START;
                    cnt_nx   = HALF_TC;
                end
            end
            S_START: begin
                if (tc) begin
                    if (rxs) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx   = S_DATA;
                        cnt_nx     = BIT_TC;
                        bit_cnt_nx = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (tc) begin
                    shreg_nx = {rxs, shreg[7:1]};
                    cnt_nx   = BIT_TC;
                    if (bit_cnt == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tc) begin
                    if (rxs) begin
                        push_req = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        ferr_req = 1'b1;
                        state_nx = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign full     = (count == FULL_CNT);
    assign rx_valid = (count != '0);
    assign pop      = rx_valid && rx_ready;
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
            frame_err <= ferr_req;
            overflow  <= push_req && full && !pop;
        end
    end

    assign rx_data    = mem[rd_ptr];
    assign fifo_count = count;

endmodule

// File: tb/tb_bf_uart_rx.sv
// Scoreboard bench for bf_uart_rx: directed scenarios plus randomized frames
// with bit-rate skew; a monitor compares every popped byte against a model queue.
`timescale 1ns/1ps
module tb_bf_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic       man_ready = 1'b0;
    logic       rnd_ready = 1'b0;
    logic       rand_en = 1'b0;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];
    int exp_ferr = 0, exp_ovf = 0, ferr_seen = 0, ovf_seen = 0;
    logic prev_ferr = 1'b0, prev_ovf = 1'b0;

    assign rx_ready = rand_en ? rnd_ready : man_ready;

    bf_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_rx_pin(pin),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared with the head of the model queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            prev_ferr = 1'b0;
            prev_ovf  = 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_data: unexpected byte %02h, model queue empty", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        miscompares++;
                        $display("FAIL pop_data: got %02h expected %02h", rx_data, e);
                    end
                end
            end
            if (frame_err) begin
                ferr_seen++;
                check("frame_err_width", int'(prev_ferr), 0);
            end
            if (overflow) begin
                ovf_seen++;
                check("overflow_width", int'(prev_ovf), 0);
            end
            prev_ferr = frame_err;
            prev_ovf  = overflow;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; bit edges placed at round(k * per10 / 10) cycles.
    task automatic send_frame(input logic [7:0] d, input int per10, input int stop_low);
        int prev_e = 0;
        int nxt;
        pin = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            nxt = (k * per10 + 5) / 10;
            repeat (nxt - prev_e) @(posedge clk);
            #1;
            prev_e = nxt;
            if (k <= 8) pin = d[k-1];
            else        pin = (stop_low > 0) ? 1'b0 : 1'b1;
        end
        if (stop_low > 0) begin
            repeat (stop_low) @(posedge clk);
            #1 pin = 1'b1;
        end else begin
            nxt = (10 * per10 + 5) / 10;
            repeat (nxt - prev_e) @(posedge clk);
            #1;
        end
    endtask

    // Reference model: good byte is stored if there is room (or a pop
    // coincides with the push), otherwise counted as an overflow.
    task automatic frame(input logic [7:0] d, input int per10, input int stop_low,
                         input bit pop_with_push);
        if (stop_low > 0)                                  exp_ferr++;
        else if (exp_q.size() < DEPTH || pop_with_push)    exp_q.push_back(d);
        else                                               exp_ovf++;
        send_frame(d, per10, stop_low);
    endtask

    task automatic drain(input string name);
        man_ready = 1'b1;
        for (int i = 0; i < 60 && (rx_valid || exp_q.size() != 0); i++) idle(1);
        man_ready = 1'b0;
        idle(1);
        check({name, "_drain_valid"}, int'(rx_valid), 0);
        check({name, "_drain_model"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int per10, stop_low;

        idle(3);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        idle(5);

        // Single frame with exact push-cycle check
        fork
            frame(8'hA5, 160, 0, 1'b0);
            begin
                repeat (154) @(posedge clk);
                #1 check("a5_before_push", int'(rx_valid), 0);
                @(posedge clk);
                #1;
                check("a5_valid", int'(rx_valid), 1);
                check("a5_data", int'(rx_data), 'hA5);
                check("a5_count", int'(fifo_count), 1);
            end
        join
        man_ready = 1'b1;
        idle(1);
        man_ready = 1'b0;
        check("a5_pop_valid", int'(rx_valid), 0);
        check("a5_pop_count", int'(fifo_count), 0);
        idle(10);

        // Glitch rejection
        pin = 1'b0;
        idle(5);
        pin = 1'b1;
        idle(40);
        check("glitch_valid", int'(rx_valid), 0);
        check("glitch_ferr", ferr_seen, exp_ferr);
        check("glitch_ovf", ovf_seen, exp_ovf);

        // Framing error then recovery
        frame(8'h3C, 160, 2 * CPB, 1'b0);
        idle(40);
        check("ferr_count", ferr_seen, exp_ferr);
        check("ferr_fifo", int'(fifo_count), 0);
        frame(8'h11, 160, 0, 1'b0);
        idle(4);
        check("after_ferr_count", int'(fifo_count), 1);
        drain("ferr");

        // Overflow
        for (int i = 1; i <= 5; i++) begin
            frame(8'(i), 160, 0, 1'b0);
            idle(4);
        end
        check("ovf_fifo", int'(fifo_count), DEPTH);
        check("ovf_pulses", ovf_seen, exp_ovf);
        drain("ovf");

        // Full FIFO with pop in the push cycle
        for (int i = 0; i < 4; i++) begin
            frame(8'(8'h61 + i), 160, 0, 1'b0);
            idle(4);
        end
        check("simul_fill", int'(fifo_count), DEPTH);
        fork
            frame(8'h66, 160, 0, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 man_ready = 1'b1;
                @(posedge clk);
                #1 man_ready = 1'b0;
            end
        join
        idle(2);
        check("simul_count", int'(fifo_count), DEPTH);
        check("simul_ovf", ovf_seen, exp_ovf);
        drain("simul");

        // Reset mid-frame during data bit 4
        frame(8'h77, 160, 0, 1'b0);
        idle(4);
        check("pre_rst_count", int'(fifo_count), 1);
        fork
            send_frame(8'hFF, 160, 0);
            begin
                repeat (82) @(posedge clk);
                #1 rst = 1'b1;
                exp_q.delete();
                #1;
                check("midrst_valid", int'(rx_valid), 0);
                check("midrst_count", int'(fifo_count), 0);
                check("midrst_ferr", int'(frame_err), 0);
                check("midrst_ovf", int'(overflow), 0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle(20);
        check("post_rst_empty", int'(fifo_count), 0);
        frame(8'h42, 160, 0, 1'b0);
        idle(4);
        check("post_rst_count", int'(fifo_count), 1);
        drain("midrst");

        // Randomized frames, +/-2.5% bit-rate skew, random ready
        rand_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d        = 8'($urandom);
            per10    = int'($urandom_range(156, 164));
            stop_low = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40)) : 0;
            frame(d, per10, stop_low, 1'b0);
            idle(int'($urandom_range(0, 30)));
        end
        idle(10);
        rand_en = 1'b0;
        drain("rand");
        check("rand_ferr", ferr_seen, exp_ferr);
        check("rand_ovf", ovf_seen, exp_ovf);
        check("rand_count", int'(fifo_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
